// File: rtl/pkt_fetch.sv
// ---------------------------------------------------------------------------
// pkt_fetch
//
// Packet fetch stage between pkt_ram and the match-action pipeline. Walks a
// contiguous packet trace in pkt_ram: each packet is a length word followed by
// len data words, and a zero length word terminates the trace. For every
// packet the length word and the first HDR_WORDS data words are gathered into
// a header vector, offered downstream on a valid/ready handshake.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin walking at start_addr (only honoured in IDLE / DONE)
//   start_addr  address of the first packet's length word
//   pkt_addr    registered pkt_ram read address
//   pkt_data    pkt_ram read data, valid the cycle after pkt_addr
//   hdr_valid   header vector available
//   hdr_ready   downstream accepts the vector
//   hdr_data    captured words, word 0 in the LSBs, unused words zero
//   hdr_len     packet length in words (length word excluded)
//   hdr_base    address of the packet's length word
//   busy        high from accepted start until the terminating word
//   done        sticky, set by the terminating word, cleared by next start
//   pkt_count   packets handed off since the last accepted start (wraps)
//
// State table
//   state  | meaning
//   IDLE   | waiting for start after reset
//   LEN    | pkt_addr points at the length word
//   LENCAP | length word on pkt_data; decide packet or end of trace
//   HDR    | driving header word addresses, capturing the previous word
//   LAST   | capturing the final header word
//   OUT    | header vector offered downstream, held until accepted
//   DONE   | trace finished; waiting for a restart
// ---------------------------------------------------------------------------
module pkt_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int HDR_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           start_addr,
    output logic [ADDR_WIDTH-1:0]           pkt_addr,
    input  logic [DATA_WIDTH-1:0]           pkt_data,
    output logic                            hdr_valid,
    input  logic                            hdr_ready,
    output logic [HDR_WORDS*DATA_WIDTH-1:0] hdr_data,
    output logic [ADDR_WIDTH-1:0]           hdr_len,
    output logic [ADDR_WIDTH-1:0]           hdr_base,
    output logic                            busy,
    output logic                            done,
    output logic [15:0]                     pkt_count
);

    localparam int CNT_W = $clog2(HDR_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LENCAP,
        HDR,
        LAST,
        OUT,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] len;
    logic [CNT_W-1:0]      k;         // index of the header word currently addressed
    logic [CNT_W-1:0]      last_idx;  // n-1, terminal value for k

    logic [ADDR_WIDTH-1:0] len_in;
    logic [CNT_W-1:0]      n_in;
    logic [CNT_W-1:0]      wr_idx;
    logic [ADDR_WIDTH-1:0] next_base;

    // base and len are only updated while no vector is offered, so they can
    // serve directly as the stable header side-band outputs.
    assign hdr_base = base;
    assign hdr_len  = len;

    always_comb begin
        len_in    = pkt_data[ADDR_WIDTH-1:0];
        n_in      = (len_in < ADDR_WIDTH'(HDR_WORDS)) ? len_in[CNT_W-1:0]
                                                      : CNT_W'(HDR_WORDS);
        // Read data lags the address by one cycle: in HDR the word arriving is
        // the one addressed last cycle; in LAST it is the one addressed by k.
        wr_idx    = (state == LAST) ? k : (k - CNT_W'(1));
        next_base = base + len + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            len       <= '0;
            k         <= '0;
            last_idx  <= '0;
            pkt_addr  <= '0;
            hdr_valid <= 1'b0;
            hdr_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base      <= start_addr;
                        pkt_addr  <= start_addr;
                        pkt_count <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= LEN;
                    end
                end

                LEN: begin
                    state <= LENCAP;
                end

                LENCAP: begin
                    len      <= len_in;
                    hdr_data <= '0;
                    if (len_in == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        last_idx <= n_in - CNT_W'(1);
                        k        <= '0;
                        pkt_addr <= base + ADDR_WIDTH'(1);
                        state    <= HDR;
                    end
                end

                HDR: begin
                    if (k != '0) begin
                        for (int i = 0; i < HDR_WORDS; i++) begin
                            if (wr_idx == CNT_W'(i))
                                hdr_data[i*DATA_WIDTH +: DATA_WIDTH] <= pkt_data;
                        end
                    end
                    // Words beyond n are skipped: the address stops advancing
                    // once the last header word has been driven.
                    if (k == last_idx) begin
                        state <= LAST;
                    end else begin
                        k        <= k + CNT_W'(1);
                        pkt_addr <= pkt_addr + ADDR_WIDTH'(1);
                    end
                end

                LAST: begin
                    for (int i = 0; i < HDR_WORDS; i++) begin
                        if (wr_idx == CNT_W'(i))
                            hdr_data[i*DATA_WIDTH +: DATA_WIDTH] <= pkt_data;
                    end
                    hdr_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (hdr_ready) begin
                        hdr_valid <= 1'b0;
                        pkt_count <= pkt_count + 16'd1;
                        base      <= next_base;
                        pkt_addr  <= next_base;
                        state     <= LEN;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_fetch.sv
module tb_pkt_fetch;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int HW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW-1:0]    pkt_addr;
    logic [DW-1:0]    pkt_data;
    logic             hdr_valid;
    logic             hdr_ready;
    logic [HW*DW-1:0] hdr_data;
    logic [AW-1:0]    hdr_len;
    logic [AW-1:0]    hdr_base;
    logic             busy;
    logic             done;
    logic [15:0]      pkt_count;

    logic [DW-1:0]    ram [0:65535];
    bit               seen [0:65535];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               xfer_cnt = 0;
    logic [AW-1:0]    q_base [$];
    logic [HW*DW-1:0] q_data [$];

    always #5 clk = ~clk;

    pkt_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .HDR_WORDS(HW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .pkt_addr   (pkt_addr),
        .pkt_data   (pkt_data),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .hdr_data   (hdr_data),
        .hdr_len    (hdr_len),
        .hdr_base   (hdr_base),
        .busy       (busy),
        .done       (done),
        .pkt_count  (pkt_count)
    );

    // Registered-read RAM model
    always @(posedge clk) pkt_data <= ram[pkt_addr];

    // Recorder: reads pre-edge values, i.e. what was presented during the cycle
    always @(posedge clk) begin
        if (!rst) begin
            if (busy) seen[pkt_addr] = 1'b1;
            if (hdr_valid && hdr_ready) begin
                xfer_cnt++;
                q_base.push_back(hdr_base);
                q_data.push_back(hdr_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec;
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        xfer_cnt = 0;
        q_base.delete();
        q_data.delete();
    endtask

    // Called just after a negedge; returns one negedge later (cycle 1).
    task automatic pulse_start(input logic [AW-1:0] a);
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_valid(input int c0, output int cyc);
        cyc = c0;
        while (!hdr_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!done && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_nxfer"}, q_base.size(), 2);
        if (q_base.size() == 2) begin
            chk({tag, "_base0"}, q_base[0], 16'h0200);
            chk({tag, "_data0"}, q_data[0], 128'h00000042_00000041);
            chk({tag, "_base1"}, q_base[1], 16'h0203);
            chk({tag, "_data1"}, q_data[1], 128'h00000051);
        end
        chk({tag, "_cnt"}, pkt_count, 16'd2);
        chk({tag, "_no300"}, seen[16'h0300], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int c;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        hdr_ready  = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        clear_rec();

        // Reset state
        #1;
        chk("rst_ctrl", {pkt_addr, hdr_valid, hdr_len, hdr_base, busy, done, pkt_count}, '0);
        chk("rst_data", hdr_data, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single packet, len 6, only 4 words fetched
        ram[0] = 32'd6;
        for (int i = 1; i <= 6; i++) ram[i] = 32'h10 + i;
        ram[7] = 32'd0;
        hdr_ready = 1'b1;
        clear_rec();
        pulse_start(16'h0000);
        chk("t1_addr_c1", pkt_addr, 16'h0000);
        wait_valid(1, cyc);
        chk("t1_latency", cyc, 8);
        chk("t1_data", hdr_data, 128'h00000014_00000013_00000012_00000011);
        chk("t1_len", hdr_len, 16'd6);
        chk("t1_base", hdr_base, 16'h0000);
        wait_done("t1_done");
        chk("t1_cnt", pkt_count, 16'd1);
        chk("t1_busy", busy, 1'b0);
        chk("t1_no_a5", seen[5], 1'b0);
        chk("t1_no_a6", seen[6], 1'b0);
        chk("t1_a7", seen[7], 1'b1);

        // Short packet, restarted from DONE
        ram[0] = 32'd2;
        ram[1] = 32'hA;
        ram[2] = 32'hB;
        ram[3] = 32'd0;
        clear_rec();
        pulse_start(16'h0000);
        wait_valid(1, cyc);
        chk("t2_latency", cyc, 6);
        chk("t2_data", hdr_data, 128'h0000000B_0000000A);
        chk("t2_len", hdr_len, 16'd2);
        wait_done("t2_done");
        chk("t2_a3", seen[3], 1'b1);
        chk("t2_addr", pkt_addr, 16'h0003);
        chk("t2_cnt", pkt_count, 16'd1);

        // Backpressure
        ram[16'h0100] = 32'd3;
        ram[16'h0101] = 32'h21;
        ram[16'h0102] = 32'h22;
        ram[16'h0103] = 32'h23;
        ram[16'h0104] = 32'd1;
        ram[16'h0105] = 32'h31;
        ram[16'h0106] = 32'd0;
        hdr_ready = 1'b0;
        clear_rec();
        pulse_start(16'h0100);
        wait_valid(1, cyc);
        chk("t3_latency", cyc, 7);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold", {hdr_valid, hdr_len, hdr_base, hdr_data},
                {1'b1, 16'd3, 16'h0100, 128'h00000023_00000022_00000021});
            @(negedge clk);
        end
        chk("t3_no_xfer", xfer_cnt, 0);
        hdr_ready = 1'b1;
        @(negedge clk);
        chk("t3_len_state", {hdr_valid, pkt_addr, pkt_count}, {1'b0, 16'h0104, 16'd1});
        chk("t3_one_xfer", xfer_cnt, 1);
        wait_valid(1, cyc);
        chk("t3_latency2", cyc, 5);
        chk("t3_pkt2", {hdr_len, hdr_base, hdr_data}, {16'd1, 16'h0104, 128'h31});
        wait_done("t3_done");
        chk("t3_cnt", pkt_count, 16'd2);
        chk("t3_xfers", xfer_cnt, 2);

        // Address wrap
        ram[16'hFFFE] = 32'd3;
        ram[16'hFFFF] = 32'h1;
        ram[16'h0000] = 32'h2;
        ram[16'h0001] = 32'h3;
        ram[16'h0002] = 32'd0;
        clear_rec();
        pulse_start(16'hFFFE);
        wait_valid(1, cyc);
        chk("t4_latency", cyc, 7);
        chk("t4_data", hdr_data, 128'h00000003_00000002_00000001);
        chk("t4_hdr", {hdr_len, hdr_base}, {16'd3, 16'hFFFE});
        wait_done("t4_done");
        chk("t4_a2", seen[2], 1'b1);
        chk("t4_addr", pkt_addr, 16'h0002);
        chk("t4_cnt", pkt_count, 16'd1);

        // Ignored start mid-packet, then restart after done
        ram[16'h0200] = 32'd2;
        ram[16'h0201] = 32'h41;
        ram[16'h0202] = 32'h42;
        ram[16'h0203] = 32'd1;
        ram[16'h0204] = 32'h51;
        ram[16'h0205] = 32'd0;
        clear_rec();
        pulse_start(16'h0200);
        @(negedge clk);
        @(negedge clk);
        pulse_start(16'h0300);
        chk("t5_busy", busy, 1'b1);
        wait_done("t5_done1");
        check_run("t5_run1");
        clear_rec();
        pulse_start(16'h0200);
        chk("t5_restart", {done, busy, pkt_count}, {1'b0, 1'b1, 16'd0});
        wait_done("t5_done2");
        check_run("t5_run2");

        // Async reset with a vector pending and pkt_count=3
        for (int i = 0; i < 4; i++) begin
            ram[16'h0400 + 2*i]     = 32'd1;
            ram[16'h0400 + 2*i + 1] = 32'h61 + i;
        end
        ram[16'h0408] = 32'd0;
        clear_rec();
        pulse_start(16'h0400);
        c = 0;
        while (pkt_count != 16'd3 && c < 200) begin
            @(negedge clk);
            c++;
        end
        hdr_ready = 1'b0;
        wait_valid(0, cyc);
        chk("t6_pre", {hdr_valid, pkt_count, hdr_data}, {1'b1, 16'd3, 128'h64});
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", {pkt_addr, hdr_valid, hdr_len, hdr_base, busy, done, pkt_count}, '0);
        chk("t6_rst_data", hdr_data, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle", {busy, hdr_valid, pkt_addr}, '0);
        hdr_ready = 1'b1;
        pulse_start(16'h0400);
        wait_valid(1, cyc);
        chk("t6_latency", cyc, 5);
        chk("t6_pkt", {hdr_base, hdr_data}, {16'h0400, 128'h61});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
